// File: rtl/psram_req_arbiter.sv
`timescale 1ns/1ps
// psram_req_arbiter
// Two-port request arbiter in front of a PSRAM burst controller. Accepts one
// burst request at a time, hands it to the controller as a registered command,
// waits for the controller's completion pulse, returns a done pulse to the
// owning port and enforces CE# recovery idle cycles between bursts.
//
// Optional feature macro: PSRAM_ARB_RR_EN
//   defined   -> round-robin tie-break using a last_grant register
//   undefined -> fixed priority, port 0 wins ties
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no burst owned; ready offered to the arbitration winner
// ISSUE     | command presented, waiting for cmd_ready
// WAIT_DONE | command taken, waiting for be_done from the controller
// GAP       | CE# recovery, GAP_CYCLES idle cycles before the next accept

module psram_req_arbiter #(
    parameter int ADDR_W     = 23,
    parameter int LEN_W      = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic              ACLK,
    input  logic              ARESETN,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [LEN_W-1:0]  req0_len,
    output logic              req0_done,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [LEN_W-1:0]  req1_len,
    output logic              req1_done,

    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_we,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [LEN_W-1:0]  cmd_len,
    output logic              cmd_id,
    input  logic              be_done,

    output logic [1:0]        grant,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } state_t;

    // The counter is loaded with GAP_CYCLES-1 so that it reads 0 in the last
    // recovery cycle; with GAP_CYCLES=0 the GAP state is never entered.
    localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    state_t     state;
    logic [3:0] gap_cnt;
    logic       win0;
    logic       win1;
    logic       accept0;
    logic       accept1;

`ifdef PSRAM_ARB_RR_EN
    logic       last_grant;

    // Round-robin winner: a lone requester wins, a tie goes to the port that
    // was not granted last.
    always_comb begin
        win0 = req0_valid && (!req1_valid || last_grant);
        win1 = req1_valid && (!req0_valid || !last_grant);
    end
`else
    // Fixed-priority winner: port 0 always wins a tie.
    always_comb begin
        win0 = req0_valid;
        win1 = req1_valid && !req0_valid;
    end
`endif

    // Ready is offered only in IDLE and is held off while reset is asserted.
    assign req0_ready = ARESETN && (state == IDLE) && win0;
    assign req1_ready = ARESETN && (state == IDLE) && win1;
    assign accept0    = req0_valid && req0_ready;
    assign accept1    = req1_valid && req1_ready;

    // Main sequencer: state, command registers, grant, busy and done pulses.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state     <= IDLE;
            gap_cnt   <= 4'd0;
            cmd_valid <= 1'b0;
            cmd_we    <= 1'b0;
            cmd_addr  <= '0;
            cmd_len   <= '0;
            cmd_id    <= 1'b0;
            grant     <= 2'b00;
            busy      <= 1'b0;
            req0_done <= 1'b0;
            req1_done <= 1'b0;
`ifdef PSRAM_ARB_RR_EN
            last_grant <= 1'b1;
`endif
        end else begin
            req0_done <= 1'b0;
            req1_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept0 || accept1) begin
                        state     <= ISSUE;
                        cmd_valid <= 1'b1;
                        busy      <= 1'b1;
                        cmd_id    <= accept1;
                        grant     <= accept1 ? 2'b10 : 2'b01;
                        cmd_we    <= accept1 ? req1_we   : req0_we;
                        cmd_addr  <= accept1 ? req1_addr : req0_addr;
                        cmd_len   <= accept1 ? req1_len  : req0_len;
`ifdef PSRAM_ARB_RR_EN
                        last_grant <= accept1;
`endif
                    end
                end
                ISSUE: begin
                    // be_done here belongs to no accepted command and is ignored.
                    if (cmd_ready) begin
                        state     <= WAIT_DONE;
                        cmd_valid <= 1'b0;
                    end
                end
                WAIT_DONE: begin
                    if (be_done) begin
                        req0_done <= !cmd_id;
                        req1_done <= cmd_id;
                        grant     <= 2'b00;
                        if (GAP_CYCLES == 0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state   <= GAP;
                            gap_cnt <= GAP_LOAD;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == 4'd0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
